// File: rtl/network_sequencer.sv
// Frame sequencer for the spiking pixel network: accept frame, hold net in reset, run window, report spike count.
// Latency: accept at edge T -> CLEAR T+1..T+SETTLE, RUN for WINDOW cycles, result_valid from T+SETTLE+WINDOW+1.
// Backpressure: frame_ready only in IDLE; the result is held in DONE until result_ready.
// Ports: clk/rst (async active-low); frame_valid/frame_ready/frame_pixels host side; abort cancels CLEAR/RUN;
//        net_rst/net_pixels/net_spike network side; result_valid/result_ready/result_count/result_sat; busy.
module network_sequencer #(
  parameter int HEIGHT  = 7,
  parameter int WINDOW  = 14336,
  parameter int SETTLE  = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic [HEIGHT-1:0]  frame_pixels,
  input  logic               abort,
  output logic               net_rst,
  output logic [HEIGHT-1:0]  net_pixels,
  input  logic               net_spike,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_sat,
  output logic               busy
);

  localparam int MAX_LEN = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  // The counter is loaded with length-1 on state entry and the state exits when it reads zero.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             spike_prev;
  logic             cnt_zero;

  assign cnt_zero = (cyc_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Outputs decode from the state register only, so no input reaches an output combinationally.
  always_comb begin
    state_nxt    = state;
    frame_ready  = 1'b0;
    net_rst      = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        frame_ready = 1'b1;
        busy        = 1'b0;
        if (frame_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (abort)         state_nxt = IDLE;
        else if (cnt_zero) state_nxt = RUN;
      end
      RUN: begin
        net_rst = 1'b1;
        if (abort)         state_nxt = IDLE;
        else if (cnt_zero) state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      net_pixels   <= '0;
      result_count <= '0;
      result_sat   <= 1'b0;
      spike_prev   <= 1'b0;
      cyc_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_valid) begin
            net_pixels   <= frame_pixels;
            result_count <= '0;
            result_sat   <= 1'b0;
            spike_prev   <= 1'b0;
            cyc_cnt      <= SETTLE_LOAD;
          end
        end
        CLEAR: begin
          // spike_prev is not sampled here, so the first RUN cycle sees a 0 history.
          if (cnt_zero) cyc_cnt <= WINDOW_LOAD;
          else          cyc_cnt <= cyc_cnt - 1'b1;
        end
        RUN: begin
          spike_prev <= net_spike;
          if (net_spike && !spike_prev) begin
            if (&result_count) result_sat   <= 1'b1;
            else               result_count <= result_count + 1'b1;
          end
          if (!cnt_zero) cyc_cnt <= cyc_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_network_sequencer.sv
module tb_network_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic [6:0]  frame_pixels;
  logic        abort;
  logic        net_spike;
  logic        result_ready;

  logic        frame_ready, net_rst, result_valid, result_sat, busy;
  logic [6:0]  net_pixels;
  logic [15:0] result_count;

  logic        frame_ready2, net_rst2, result_valid2, result_sat2, busy2;
  logic [6:0]  net_pixels2;
  logic [1:0]  result_count2;

  int checks = 0;
  int errors = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  network_sequencer #(.HEIGHT(7), .WINDOW(16), .SETTLE(2), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_pixels(frame_pixels), .abort(abort), .net_rst(net_rst), .net_pixels(net_pixels),
    .net_spike(net_spike), .result_valid(result_valid), .result_ready(result_ready),
    .result_count(result_count), .result_sat(result_sat), .busy(busy)
  );

  // Narrow-count copy on the same stimulus, for saturation behaviour.
  network_sequencer #(.HEIGHT(7), .WINDOW(16), .SETTLE(2), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready2),
    .frame_pixels(frame_pixels), .abort(abort), .net_rst(net_rst2), .net_pixels(net_pixels2),
    .net_spike(net_spike), .result_valid(result_valid2), .result_ready(result_ready),
    .result_count(result_count2), .result_sat(result_sat2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_ready"}, frame_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_net_rst"}, net_rst, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_net_pixels"}, net_pixels, 0);
    check({tag, "_result_count"}, result_count, 0);
    check({tag, "_result_sat"}, result_sat, 0);
  endtask

  // Monitor: pops one expected count per completed result handshake.
  always @(negedge clk) begin
    if (rst && result_valid && result_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got count %0d, expected no result", result_count);
      end else begin
        int e;
        e = sb_q.pop_front();
        check("result_count", result_count, e);
        check("result_sat", result_sat, 0);
        check("sat_dut_valid", result_valid2, 1);
        check("sat_dut_count", result_count2, (e > 3) ? 3 : e);
        check("sat_dut_sat", result_sat2, (e > 3) ? 1 : 0);
      end
    end
  end

  // spk bit k drives net_spike in cycle T+1+k (accept at edge T):
  // k=0..1 CLEAR, k=2..17 RUN, k=18 DONE. hold = extra DONE cycles with result_ready low.
  task automatic run_frame(input logic [6:0] pix, input logic [31:0] spk, input int exp, input int hold);
    sb_q.push_back(exp);
    result_ready = (hold == 0);
    frame_pixels = pix;
    frame_valid  = 1'b1;
    tick();
    frame_valid  = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      net_spike = spk[k];
      check("net_rst", net_rst, (k >= 2 && k < 18) ? 1 : 0);
      check("result_valid", result_valid, (k == 18) ? 1 : 0);
      check("net_pixels", net_pixels, pix);
      check("busy", busy, 1);
      check("frame_ready", frame_ready, 0);
      if (k < 18) tick();
    end
    net_spike = 1'b0;
    for (int i = 0; i < hold; i++) begin
      frame_valid  = 1'b1;
      frame_pixels = ~pix;
      check("bp_result_valid", result_valid, 1);
      check("bp_result_count", result_count, exp);
      check("bp_frame_ready", frame_ready, 0);
      check("bp_net_pixels", net_pixels, pix);
      tick();
    end
    result_ready = 1'b1;
    tick();
    check("post_busy", busy, 0);
    check("post_frame_ready", frame_ready, 1);
    check("post_result_valid", result_valid, 0);
    check("post_net_rst", net_rst, 0);
  endtask

  initial begin
    rst          = 1'b0;
    frame_valid  = 1'b0;
    frame_pixels = '0;
    abort        = 1'b0;
    net_spike    = 1'b0;
    result_ready = 1'b1;
    #2;
    check_reset_outputs("rst_hold");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    run_frame(7'b0101010, 32'h0000_0448, 3, 0);   // three isolated pulses in RUN
    run_frame(7'h11,      32'hFFFF_FFFF, 1, 0);   // held high CLEAR..DONE
    run_frame(7'h22,      32'h0004_0003, 0, 0);   // pulses only in CLEAR and DONE
    run_frame(7'h44,      32'h0002_0004, 2, 0);   // edges in first and last RUN cycle
    run_frame(7'h7F,      32'h0000_0554, 5, 0);   // five pulses: narrow copy saturates
    run_frame(7'h0F,      32'h0000_0015, 2, 10);  // backpressure; frame_valid stays high
    run_frame(7'h3C,      32'h0000_0100, 1, 0);   // the waiting frame is accepted next edge

    // Abort on the 5th RUN cycle.
    frame_pixels = 7'h33;
    frame_valid  = 1'b1;
    tick();
    frame_valid  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      net_spike = (k == 3);
      tick();
    end
    net_spike = 1'b0;
    check("abort_pre_net_rst", net_rst, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_net_rst", net_rst, 0);
    check("abort_frame_ready", frame_ready, 1);
    check("abort_net_pixels", net_pixels, 7'h33);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_result", result_valid, 0);
      tick();
    end
    run_frame(7'h2A, 32'h0000_0004, 1, 0);

    // Asynchronous reset in the middle of RUN.
    frame_pixels = 7'h55;
    frame_valid  = 1'b1;
    tick();
    frame_valid  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      net_spike = (k == 2);
      tick();
    end
    net_spike = 1'b0;
    check("midrun_net_rst", net_rst, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_midrun");
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_midrun_rel");

    run_frame(7'h05, 32'h0000_0448, 3, 0);

    tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
